// File: rtl/bench_slot_scheduler.sv
// Benchmark slot sequencer: walks enabled slots, pulses dut_rst, dwells, and signs each slot's output (SCHED_MISR_EN = MISR signature).
// Latency: start -> dut_rst 1 cycle, RST_CYCLES+DWELL_CYCLES+1 per slot; no backpressure, start/inputs ignored while busy.
module bench_slot_scheduler #(
    parameter int DWELL_CYCLES = 16,
    parameter int RST_CYCLES   = 2,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] slot_en,
    input  logic       manual,
    input  logic [2:0] manual_sel,
    input  logic [7:0] dut_out,
    output logic [2:0] sel,
    output logic       dut_rst,
    output logic       busy,
    output logic [7:0] sig,
    output logic [2:0] sig_slot,
    output logic       sig_valid,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_REPORT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       mask;
    logic [7:0]       acc;
    logic [7:0]       acc_next;
    logic             first_hit;
    logic [2:0]       first_idx;
    logic             next_hit;
    logic [2:0]       next_idx;

    // Descending scan so the last hit written is the lowest qualifying index.
    always_comb begin
        first_hit = 1'b0;
        first_idx = 3'd0;
        next_hit  = 1'b0;
        next_idx  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (slot_en[i]) begin
                first_hit = 1'b1;
                first_idx = 3'(i);
            end
            if (mask[i] && (i > int'(sel))) begin
                next_hit = 1'b1;
                next_idx = 3'(i);
            end
        end
    end

`ifdef SCHED_MISR_EN
    assign acc_next = {acc[6:0], acc[7] ^ acc[5] ^ acc[4] ^ acc[3]} ^ dut_out;
`else
    // Capture mode: the seed could only survive a zero-length dwell, which the parameter range excludes.
    assign acc_next = (DWELL_CYCLES > 0) ? dut_out : acc;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mask      <= 8'h00;
            acc       <= 8'h00;
            sel       <= 3'd0;
            dut_rst   <= 1'b0;
            busy      <= 1'b0;
            sig       <= 8'h00;
            sig_slot  <= 3'd0;
            sig_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    sig_valid <= 1'b0;
                    done      <= 1'b0;
                    dut_rst   <= 1'b0;
                    if (start) begin
                        mask <= slot_en;
                        cnt  <= '0;
                        busy <= 1'b1;
                        if (first_hit) begin
                            sel     <= first_idx;
                            dut_rst <= 1'b1;
                            state   <= S_RST;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end else if (manual) begin
                        sel <= manual_sel;
                    end
                end
                S_RST: begin
                    if (cnt == RST_LAST) begin
                        cnt     <= '0;
                        dut_rst <= 1'b0;
                        acc     <= 8'hFF;
                        state   <= S_RUN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    acc <= acc_next;
                    if (cnt == DWELL_LAST) begin
                        cnt       <= '0;
                        sig       <= acc_next;
                        sig_slot  <= sel;
                        sig_valid <= 1'b1;
                        state     <= S_REPORT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_REPORT: begin
                    sig_valid <= 1'b0;
                    if (next_hit) begin
                        sel     <= next_idx;
                        dut_rst <= 1'b1;
                        state   <= S_RST;
                    end else begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
